// File: rtl/systolic_sched.sv
// systolic_sched: control sequencer for a SIZE x SIZE weight-stationary systolic array.
// Loads B into the PE columns, streams skewed rows of A, then captures the bottom-row
// partial sums into C = A x B.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   abort           (only with SCHED_ABORT_EN) cancel the running multiply
//   start           request a multiply; mat_a / mat_b are latched when accepted
//   mat_a, mat_b    packed operands, element [i][j] at offset (i*SIZE+j)*DATA_WIDTH
//   busy, done      activity flag and one-cycle completion pulse
//   pe_data         activation for array row r (slice r)
//   pe_weight       weight for array column c (slice c), shifted in while shift_en=1
//   pe_valid        in_valid for array row r
//   shift_en        weight-shift enable to all PEs
//   psum_in         bottom-row part_sum_out for column c (slice c)
//   result          packed C, same packing as mat_a, ACC_WIDTH per element
//   res_valid       result holds a complete C
//
// Build option: define SCHED_ABORT_EN to add the abort input.

module systolic_sched #(
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = 9,
    parameter int SIZE       = 2,
    parameter int PE_LAT     = 1
) (
    input  logic                                clk,
    input  logic                                rst,
`ifdef SCHED_ABORT_EN
    input  logic                                abort,
`endif
    input  logic                                start,
    input  logic [SIZE*SIZE*DATA_WIDTH-1:0]     mat_a,
    input  logic [SIZE*SIZE*DATA_WIDTH-1:0]     mat_b,
    output logic                                busy,
    output logic                                done,
    output logic [SIZE*DATA_WIDTH-1:0]          pe_data,
    output logic [SIZE*DATA_WIDTH-1:0]          pe_weight,
    output logic [SIZE-1:0]                     pe_valid,
    output logic                                shift_en,
    input  logic [SIZE*ACC_WIDTH-1:0]           psum_in,
    output logic [SIZE*SIZE*ACC_WIDTH-1:0]      result,
    output logic                                res_valid
);

    // Last step of STREAM and the step of the final bottom-right capture.
    localparam int T_STREAM = 2*SIZE - 2;
    localparam int T_LAST   = 3*SIZE - 3 + PE_LAT;
    localparam int T_MAX    = (T_LAST > SIZE) ? T_LAST : SIZE;
    localparam int TW       = $clog2(T_MAX + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                           state_q, state_d;
    logic [TW-1:0]                    t_q, t_d;
    logic [DATA_WIDTH-1:0]            a_q [SIZE][SIZE];
    logic [DATA_WIDTH-1:0]            b_q [SIZE][SIZE];
    logic [SIZE*SIZE*ACC_WIDTH-1:0]   res_q, res_d;
    logic                             res_valid_q, res_valid_d;
    logic                             accept;
    int                               t_int;

    assign t_int = int'(t_q);

    // Next state, step counter and result-valid flag.
    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        res_valid_d = res_valid_q;
        accept      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept      = 1'b1;
                    state_d     = S_LOAD_W;
                    t_d         = '0;
                    res_valid_d = 1'b0;
                end
            end
            S_LOAD_W: begin
                if (t_int == SIZE - 1) begin
                    state_d = S_STREAM;
                    t_d     = '0;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            S_STREAM: begin
                t_d = t_q + TW'(1);
                if (t_int == T_STREAM)
                    state_d = (T_STREAM >= T_LAST) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                t_d = t_q + TW'(1);
                if (t_int >= T_LAST)
                    state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
        endcase
`ifdef SCHED_ABORT_EN
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            t_d     = '0;
        end
`endif
        if (state_d == S_DONE)
            res_valid_d = 1'b1;
    end

    // C[i][c] leaves the bottom of column c at step i+(SIZE-1)+c+PE_LAT.
    always_comb begin
        res_d = res_q;
        if (state_q == S_STREAM || state_q == S_DRAIN) begin
            for (int i = 0; i < SIZE; i++) begin
                for (int c = 0; c < SIZE; c++) begin
                    if (t_int == i + SIZE - 1 + c + PE_LAT)
                        res_d[(i*SIZE+c)*ACC_WIDTH +: ACC_WIDTH] =
                            psum_in[c*ACC_WIDTH +: ACC_WIDTH];
                end
            end
        end
    end

    // Array-side outputs. Weights enter bottom row first so row r ends up
    // holding B[r][*]; activations are skewed by one step per row.
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        shift_en  = (state_q == S_LOAD_W);
        pe_weight = '0;
        pe_data   = '0;
        pe_valid  = '0;
        if (state_q == S_LOAD_W) begin
            for (int k = 0; k < SIZE; k++) begin
                for (int c = 0; c < SIZE; c++) begin
                    if (t_int == k)
                        pe_weight[c*DATA_WIDTH +: DATA_WIDTH] = b_q[SIZE-1-k][c];
                end
            end
        end
        if (state_q == S_STREAM) begin
            for (int r = 0; r < SIZE; r++) begin
                for (int i = 0; i < SIZE; i++) begin
                    if (t_int - r == i) begin
                        pe_valid[r] = 1'b1;
                        pe_data[r*DATA_WIDTH +: DATA_WIDTH] = a_q[i][r];
                    end
                end
            end
        end
    end

    assign result    = res_q;
    assign res_valid = res_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            t_q         <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    a_q[i][j] <= '0;
                    b_q[i][j] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            if (accept) begin
                for (int i = 0; i < SIZE; i++) begin
                    for (int j = 0; j < SIZE; j++) begin
                        a_q[i][j] <= mat_a[(i*SIZE+j)*DATA_WIDTH +: DATA_WIDTH];
                        b_q[i][j] <= mat_b[(i*SIZE+j)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_sched.sv
// tb_systolic_sched: drives systolic_sched against a cycle model of a 2x2 PE array;
// expected C comes from a plain matrix multiply pushed to a scoreboard queue.

module tb_systolic_sched;

    localparam int DW  = 4;
    localparam int AW  = 9;
    localparam int S   = 2;
    localparam int PL  = 1;
    localparam int MW  = S*S*DW;
    localparam int RW  = S*S*AW;
    localparam int TOT = S + (3*S - 3 + PL) + 2;

    logic            clk;
    logic            rst;
    logic            start;
    logic [MW-1:0]   mat_a, mat_b;
    logic            busy, done, shift_en, res_valid;
    logic [S*DW-1:0] pe_data, pe_weight;
    logic [S-1:0]    pe_valid;
    logic [S*AW-1:0] psum_in;
    logic [RW-1:0]   result;
`ifdef SCHED_ABORT_EN
    logic            abort;
`endif

    typedef struct {
        logic [RW-1:0] res;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   nt = 0;
    int   nf = 0;
    int   cyc = 0;

    systolic_sched #(
        .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SIZE(S), .PE_LAT(PL)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef SCHED_ABORT_EN
        .abort(abort),
`endif
        .start(start),
        .mat_a(mat_a),
        .mat_b(mat_b),
        .busy(busy),
        .done(done),
        .pe_data(pe_data),
        .pe_weight(pe_weight),
        .pe_valid(pe_valid),
        .shift_en(shift_en),
        .psum_in(psum_in),
        .result(result),
        .res_valid(res_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PE array: weight-stationary, data moves right, psum moves down, latency 1.
    logic [DW-1:0] pd [S][S], din [S][S], pw [S][S], win [S][S];
    logic          pv [S][S], vin [S][S];
    logic [AW-1:0] ps [S][S], pin [S][S];

    always_comb begin
        for (int r = 0; r < S; r++) begin
            for (int c = 0; c < S; c++) begin
                din[r][c] = (c == 0) ? pe_data[r*DW +: DW] : pd[r][(c == 0) ? 0 : c-1];
                vin[r][c] = (c == 0) ? pe_valid[r] : pv[r][(c == 0) ? 0 : c-1];
                pin[r][c] = (r == 0) ? '0 : ps[(r == 0) ? 0 : r-1][c];
                win[r][c] = (r == 0) ? pe_weight[c*DW +: DW] : pw[(r == 0) ? 0 : r-1][c];
            end
        end
        psum_in = '0;
        for (int c = 0; c < S; c++)
            psum_in[c*AW +: AW] = ps[S-1][c];
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < S; r++) begin
            for (int c = 0; c < S; c++) begin
                pd[r][c] <= din[r][c];
                pv[r][c] <= vin[r][c];
                if (shift_en)
                    pw[r][c] <= win[r][c];
                ps[r][c] <= pin[r][c] +
                    (vin[r][c] ? AW'(din[r][c]) * AW'(pw[r][c]) : '0);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nt++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int el(input logic [MW-1:0] m, input int i, input int j);
        return int'(m[(i*S+j)*DW +: DW]);
    endfunction

    function automatic logic [RW-1:0] matmul(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [RW-1:0] r;
        int sum;
        r = '0;
        for (int i = 0; i < S; i++) begin
            for (int j = 0; j < S; j++) begin
                sum = 0;
                for (int k = 0; k < S; k++)
                    sum += el(a, i, k) * el(b, k, j);
                r[(i*S+j)*AW +: AW] = sum[AW-1:0];
            end
        end
        return r;
    endfunction

    function automatic logic [MW-1:0] mk(input int e00, input int e01, input int e10, input int e11);
        logic [MW-1:0] m;
        m = '0;
        m[0*DW +: DW] = DW'(e00);
        m[1*DW +: DW] = DW'(e01);
        m[2*DW +: DW] = DW'(e10);
        m[3*DW +: DW] = DW'(e11);
        return m;
    endfunction

    // Monitor: every done pulse must match the oldest pending run.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                nt++;
                nf++;
                $display("FAIL spurious_done: got done=1 expected no pending run (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("result", result, mon_e.res);
                chk("done_cycle", cyc + 1, mon_e.cyc);
                chk("res_valid_at_done", res_valid, 1);
            end
        end
    end

    // Called at a negedge while idle; start is sampled at the next edge n0.
    task automatic issue(input logic [MW-1:0] a, input logic [MW-1:0] b, output int n0);
        exp_t e;
        mat_a = a;
        mat_b = b;
        start = 1'b1;
        n0    = cyc + 1;
        e.res = matmul(a, b);
        e.cyc = n0 + TOT;
        sb.push_back(e);
    endtask

    // Per-cycle trace of the array-side outputs for one run.
    task automatic follow(input logic [MW-1:0] a, input logic [MW-1:0] b, input bit inj);
        logic [S*DW-1:0] ew, ed;
        logic [S-1:0]    ev;
        logic            esh;
        int              t;
        for (int k = 1; k <= TOT; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
`ifdef SCHED_ABORT_EN
                abort = 1'b0;
`endif
            end
            ew = '0; ed = '0; ev = '0; esh = 1'b0;
            if (k <= S) begin
                esh = 1'b1;
                for (int c = 0; c < S; c++)
                    ew[c*DW +: DW] = b[((S-k)*S+c)*DW +: DW];
            end else if (k <= 3*S - 1) begin
                t = k - S - 1;
                for (int r = 0; r < S; r++) begin
                    if (t - r >= 0 && t - r < S) begin
                        ev[r] = 1'b1;
                        ed[r*DW +: DW] = a[((t-r)*S+r)*DW +: DW];
                    end
                end
            end
            chk("busy", busy, 1);
            chk("shift_en", shift_en, esh);
            chk("pe_weight", pe_weight, ew);
            chk("pe_valid", pe_valid, ev);
            chk("pe_data", pe_data, ed);
            chk("done_pulse", done, k == TOT);
            chk("res_valid_run", res_valid, k == TOT);
            if (inj && k == S + 2) start = 1'b1;
            if (inj && k == S + 3) start = 1'b0;
            if (inj && k == TOT)   start = 1'b1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pe_data"}, pe_data, 0);
        chk({tag, "_pe_weight"}, pe_weight, 0);
        chk({tag, "_pe_valid"}, pe_valid, 0);
        chk({tag, "_shift_en"}, shift_en, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [MW-1:0] a, b, a2, b2;
        logic [RW-1:0] keep;
        int n0;
        rst = 1'b1; start = 1'b0; mat_a = '0; mat_b = '0;
`ifdef SCHED_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Known 2x2 product.
        a = mk(1, 2, 3, 4);
        b = mk(5, 6, 7, 8);
        issue(a, b, n0);
        follow(a, b, 1'b0);
        chk("C00", result[0*AW +: AW], 19);
        chk("C01", result[1*AW +: AW], 22);
        chk("C10", result[2*AW +: AW], 43);
        chk("C11", result[3*AW +: AW], 50);
        keep = result;
        repeat (3) @(negedge clk);
        chk("hold_result", result, keep);
        chk("hold_res_valid", res_valid, 1);
        chk("idle_busy", busy, 0);

        // Largest operands.
        a = '1;
        b = '1;
        issue(a, b, n0);
        follow(a, b, 1'b0);
        chk("C_all15", result[3*AW +: AW], 450);
        @(negedge clk);

        // Starts during STREAM and DONE are ignored; the next cycle's start is taken.
        a = MW'($urandom);
        b = MW'($urandom);
        issue(a, b, n0);
        follow(a, b, 1'b1);
        @(negedge clk);
        chk("done_start_ignored", busy, 0);
        a2 = MW'($urandom);
        b2 = MW'($urandom);
        issue(a2, b2, n0);
        follow(a2, b2, 1'b0);
        @(negedge clk);

        // Reset in the middle of a run.
        a = MW'($urandom);
        b = MW'($urandom);
        issue(a, b, n0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        a = MW'($urandom);
        b = MW'($urandom);
        issue(a, b, n0);
        follow(a, b, 1'b0);
        @(negedge clk);

`ifdef SCHED_ABORT_EN
        a = MW'($urandom);
        b = MW'($urandom);
        issue(a, b, n0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        sb.delete();
        chk("abort_busy", busy, 0);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_pe_valid", pe_valid, 0);
        chk("abort_shift_en", shift_en, 0);
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        abort = 1'b1;
        @(negedge clk);
        chk("idle_abort_ignored", busy, 0);
        a = MW'($urandom);
        b = MW'($urandom);
        issue(a, b, n0);
        follow(a, b, 1'b0);
        @(negedge clk);
`endif

        // Random operands, with random idle gaps.
        for (int n = 0; n < 6; n++) begin
            a = MW'($urandom);
            b = MW'($urandom);
            issue(a, b, n0);
            follow(a, b, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end

endmodule
